register_write_arbiter: RTL and testbench

- Shares the single write port of the `register` bank among NUM_REQ requesters.
  - Register bank interface: one-hot per-register write enable, shared write data.
- Each requester presents a valid/ready request carrying a target register index and data.
- The arbiter grants one request per cycle in round-robin order and drives a registered one-hot write enable plus data into the bank.
- Sits directly in front of `register`; its outputs connect to the bank's i_write_enable and i_write_data.

---
 rtl/register_write_arbiter_if.sv | 28 ++
 rtl/register_write_arbiter.sv | 102 ++++++++++
 tb/tb_register_write_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/register_write_arbiter_if.sv
// Request/write bus between the requesters, the write arbiter and the register bank.
// Requester side uses the master modport; the arbiter uses the slave modport.
interface register_write_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REG    = 6,
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_W     = $clog2(NUM_REG)
);
    logic                          hold;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_W-1:0]     req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REG-1:0]            write_enable;
    logic [DATA_WIDTH-1:0]         write_data;
    logic                          err;
    logic [NUM_REQ-1:0]            last_grant;

    modport master (
        output hold, req_valid, req_addr, req_data,
        input  req_ready, write_enable, write_data, err, last_grant
    );

    modport slave (
        input  hold, req_valid, req_addr, req_data,
        output req_ready, write_enable, write_data, err, last_grant
    );
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port among NUM_REQ requesters.
// Optional macro REGARB_PRIO0_EN: requester 0 gets strict priority, the rest share round-robin.
module register_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REG    = 6,
    parameter int unsigned NUM_REQ    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    register_write_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(NUM_REG);
    localparam int unsigned PTR_W  = $clog2(NUM_REQ);
`ifdef REGARB_PRIO0_EN
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(1);
`else
    localparam logic [PTR_W-1:0] PTR_RST = '0;
`endif

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]    grant_c;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  in_range_c;

    // Grant search: first valid requester at or above the pointer, with wrap.
    always_comb begin
        logic [PTR_W-1:0] k;
        grant_c   = '0;
        grant_idx = '0;
        k         = '0;
        if (!rst && !bus.hold) begin
`ifdef REGARB_PRIO0_EN
            if (bus.req_valid[0]) begin
                grant_c[0] = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NUM_REQ - 1; i++) begin
                    k = PTR_W'(1 + ((32'(ptr) - 1 + i) % (NUM_REQ - 1)));
                    if (grant_c == '0 && bus.req_valid[k]) begin
                        grant_c[k] = 1'b1;
                        grant_idx  = k;
                    end
                end
            end
`else
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                k = PTR_W'((32'(ptr) + i) % NUM_REQ);
                if (grant_c == '0 && bus.req_valid[k]) begin
                    grant_c[k] = 1'b1;
                    grant_idx  = k;
                end
            end
`endif
        end
    end

    // One-hot mux of the granted requester's index and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (grant_c[r]) begin
                sel_addr = sel_addr | bus.req_addr[r*ADDR_W +: ADDR_W];
                sel_data = sel_data | bus.req_data[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        in_range_c = (32'(sel_addr) < NUM_REG);
    end

    assign bus.req_ready = grant_c;

    // Registered write port; enable and error are single-cycle pulses per transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr              <= PTR_RST;
            bus.write_enable <= '0;
            bus.write_data   <= '0;
            bus.err          <= 1'b0;
            bus.last_grant   <= '0;
        end else begin
            bus.write_enable <= '0;
            bus.err          <= 1'b0;
            if (|grant_c) begin
                bus.write_data <= sel_data;
                bus.last_grant <= grant_c;
                if (in_range_c) begin
                    bus.write_enable <= NUM_REG'(1) << sel_addr;
                end else begin
                    bus.err <= 1'b1;
                end
`ifdef REGARB_PRIO0_EN
                if (grant_idx != '0) begin
                    ptr <= (32'(grant_idx) == NUM_REQ - 1) ? PTR_W'(1) : grant_idx + 1'b1;
                end
`else
                ptr <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter with a round-robin reference model and write scoreboard.
module tb_register_write_arbiter;
    localparam int unsigned DW = 8;
    localparam int unsigned NR = 6;
    localparam int unsigned NQ = 3;
    localparam int unsigned AW = 3;

    typedef struct packed {
        logic          err;
        logic [NR-1:0] we;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    register_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REG(NR), .NUM_REQ(NQ)) bus ();

    register_write_arbiter #(.DATA_WIDTH(DW), .NUM_REG(NR), .NUM_REQ(NQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int            n_pass  = 0;
    int            n_total = 0;
    wr_t           q[$];
    int            ptr_m   = 0;
    logic [NQ-1:0] last_m  = '0;
    logic [DW-1:0] data_m  = '0;
    logic [DW-1:0] bank [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [NQ-1:0] model_grant();
        int k;
        if (rst || bus.hold) return '0;
        for (int i = 0; i < NQ; i++) begin
            k = (ptr_m + i) % NQ;
            if (bus.req_valid[k]) return NQ'(1 << k);
        end
        return '0;
    endfunction

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_addr[k*AW +: AW] = a;
        bus.req_data[k*DW +: DW] = d;
    endtask

    // One cycle: check outputs of the last edge, check/predict this cycle's grant, advance.
    task automatic tick(input string tag);
        wr_t           e;
        logic [NQ-1:0] g;
        int            gi;
        logic [AW-1:0] a;
        #1;
        if (rst) begin
            q.delete();
            ptr_m  = 0;
            last_m = '0;
            data_m = '0;
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_we"},   32'(bus.write_enable), 32'(e.we));
            chk({tag, "_data"}, 32'(bus.write_data),   32'(e.data));
            chk({tag, "_err"},  32'(bus.err),          32'(e.err));
            data_m = e.data;
        end else begin
            chk({tag, "_we_idle"},   32'(bus.write_enable), 32'(0));
            chk({tag, "_err_idle"},  32'(bus.err),          32'(0));
            chk({tag, "_data_hold"}, 32'(bus.write_data),   32'(data_m));
        end
        chk({tag, "_last_grant"}, 32'(bus.last_grant), 32'(last_m));
        for (int r = 0; r < NR; r++) if (bus.write_enable[r]) bank[r] = bus.write_data;
        g = model_grant();
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(g));
        if (g != '0) begin
            gi = 0;
            for (int i = 0; i < NQ; i++) if (g[i]) gi = i;
            a      = bus.req_addr[gi*AW +: AW];
            e.data = bus.req_data[gi*DW +: DW];
            if (a < NR) begin
                e.we  = NR'(1) << a;
                e.err = 1'b0;
            end else begin
                e.we  = '0;
                e.err = 1'b1;
            end
            q.push_back(e);
            ptr_m  = (gi + 1) % NQ;
            last_m = g;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int r = 0; r < NR; r++) bank[r] = '0;
        bus.hold      = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        // Reset held with all requesters valid.
        set_req(0, 3'd0, 8'h10);
        set_req(1, 3'd1, 8'h20);
        set_req(2, 3'd2, 8'h30);
        bus.req_valid = 3'b111;
        @(posedge clk);
        #1;
        tick("rst0");
        tick("rst1");
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(bus.req_ready), 32'h1);

        // Fairness: continuous back-to-back grants 0,1,2,0,1,2.
        repeat (6) tick("fair");
        bus.req_valid = '0;
        tick("fair_drain");

        // Single write to reg2.
        set_req(1, 3'd2, 8'hAA);
        bus.req_valid = 3'b010;
        tick("single");
        bus.req_valid = '0;
        tick("single_wr");
        tick("single_idle");
        chk("bank_reg2", 32'(bank[2]), 32'hAA);

        // Out-of-range index from requester 0.
        set_req(0, 3'd7, 8'h55);
        bus.req_valid = 3'b001;
        tick("oor");
        bus.req_valid = '0;
        tick("oor_err");
        set_req(0, 3'd0, 8'h11);
        bus.req_valid = 3'b111;
        #1;
        chk("oor_ptr", 32'(bus.req_ready), 32'h2);
        tick("oor_next");
        bus.req_valid = '0;
        tick("oor_drain");

        // Hold blocks grants, release resumes immediately.
        bus.hold      = 1'b1;
        bus.req_valid = 3'b010;
        repeat (3) tick("hold");
        bus.hold = 1'b0;
        tick("unhold");
        bus.req_valid = '0;
        tick("unhold_wr");

        // Reset right after a handshake discards the pending write.
        set_req(2, 3'd3, 8'h77);
        bus.req_valid = 3'b100;
        tick("pre_rst");
        rst           = 1'b1;
        bus.req_valid = 3'b111;
        tick("mid_rst");
        rst = 1'b0;
        #1;
        chk("rst_ptr", 32'(bus.req_ready), 32'h1);
        tick("post_rst");
        bus.req_valid = '0;
        tick("post_rst_wr");
        tick("post_rst_idle");
        chk("bank_reg3", 32'(bank[3]), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
